// File: rtl/fc_w_fetch_if.sv
// Weight-fetch bus bundle: DMA read descriptor channel, DMA read data
// stream, and the write side of the downstream weight FIFO.
// The fetcher drives the master side; the environment drives the slave side.
interface fc_w_fetch_if #(
    parameter int DATA_W = 512
);
    localparam int B = DATA_W / 8;

    logic [31:0]       dma_rd_desc_addr;
    logic [31:0]       dma_rd_desc_len;
    logic              dma_rd_desc_valid;
    logic              dma_rd_desc_ready;

    logic [DATA_W-1:0] dma_rd_read_data_tdata;
    logic              dma_rd_read_data_tvalid;
    logic              dma_rd_read_data_tlast;
    logic              dma_rd_read_data_tready;

    logic              w_fifo_wr_en;
    logic [B*9-1:0]    w_fifo_din;
    logic              w_fifo_prog_full;

    modport master (
        output dma_rd_desc_addr, dma_rd_desc_len, dma_rd_desc_valid,
        input  dma_rd_desc_ready,
        input  dma_rd_read_data_tdata, dma_rd_read_data_tvalid, dma_rd_read_data_tlast,
        output dma_rd_read_data_tready,
        output w_fifo_wr_en, w_fifo_din,
        input  w_fifo_prog_full
    );

    modport slave (
        input  dma_rd_desc_addr, dma_rd_desc_len, dma_rd_desc_valid,
        output dma_rd_desc_ready,
        output dma_rd_read_data_tdata, dma_rd_read_data_tvalid, dma_rd_read_data_tlast,
        input  dma_rd_read_data_tready,
        input  w_fifo_wr_en, w_fifo_din,
        output w_fifo_prog_full
    );
endinterface

// File: rtl/fc_w_fetch.sv
// FC weight fetcher: splits a weight region into chunk-bounded DMA read
// descriptors, converts each returned beat to zero-point-corrected 9-bit
// signed lanes and writes them to the weight FIFO one cycle later.
module fc_w_fetch #(
    parameter int DATA_W      = 512,
    parameter int CHUNK_BYTES = 4096,
    parameter int MAX_OUT     = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start_pulse,
    input  logic [31:0]  w_addr,
    input  logic [31:0]  w_n_bytes,
    input  logic [7:0]   wz,
    output logic         done_pulse,
    output logic         busy,
    output logic         err_tlast,
    fc_w_fetch_if.master dma
);
    localparam int B  = DATA_W / 8;
    localparam int BW = $clog2(B);
    localparam int CW = $clog2(CHUNK_BYTES);
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]    desc_addr, desc_rem, chunk_room, desc_len;
    logic [31:0]    data_addr, data_addr_nxt, beat_cnt, beat_total;
    logic [OW-1:0]  outstanding;
    logic [7:0]     wz_r;
    logic [B*9-1:0] lanes;
    logic           start_ok, desc_fire, beat, tlast_fire, beat_last_exp;

    assign start_ok   = start_pulse && (state == IDLE);
    assign busy       = (state != IDLE);
    assign done_pulse = (state == DONE);

    // Descriptor never crosses a chunk boundary: clip to the room left in it.
    assign chunk_room = 32'(CHUNK_BYTES) - 32'(desc_addr[CW-1:0]);
    assign desc_len   = (desc_rem < chunk_room) ? desc_rem : chunk_room;

    assign dma.dma_rd_desc_addr  = desc_addr;
    assign dma.dma_rd_desc_len   = desc_len;
    assign dma.dma_rd_desc_valid = (state == RUN) && (desc_rem != 32'd0) &&
                                   (outstanding < OW'(MAX_OUT));
    assign desc_fire = dma.dma_rd_desc_valid && dma.dma_rd_desc_ready;

    assign dma.dma_rd_read_data_tready = (state == RUN) && !dma.w_fifo_prog_full;
    assign beat       = dma.dma_rd_read_data_tvalid && dma.dma_rd_read_data_tready;
    assign tlast_fire = beat && dma.dma_rd_read_data_tlast && (outstanding != '0);

    // Data side re-derives the descriptor boundaries from its own address, so
    // the expected tlast position needs no per-descriptor bookkeeping.
    assign data_addr_nxt = data_addr + 32'(B);
    assign beat_last_exp = (data_addr_nxt[CW-1:0] == '0) || (beat_cnt + 32'd1 == beat_total);

    for (genvar i = 0; i < B; i++) begin : g_lane
        assign lanes[9*i +: 9] = {1'b0, dma.dma_rd_read_data_tdata[8*i +: 8]} - {1'b0, wz_r};
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: RUN ends once every expected beat has been received.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_pulse) state_nxt = (w_n_bytes == 32'd0) ? DONE : RUN;
            RUN:     if (beat_cnt == beat_total) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer bookkeeping: descriptor walk, beat count, outstanding, tlast check.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            desc_addr   <= '0;
            desc_rem    <= '0;
            data_addr   <= '0;
            beat_cnt    <= '0;
            beat_total  <= '0;
            outstanding <= '0;
            wz_r        <= '0;
            err_tlast   <= 1'b0;
        end else if (start_ok) begin
            desc_addr   <= w_addr;
            desc_rem    <= w_n_bytes;
            data_addr   <= w_addr;
            beat_cnt    <= '0;
            beat_total  <= w_n_bytes >> BW;
            outstanding <= '0;
            wz_r        <= wz;
            err_tlast   <= 1'b0;
        end else begin
            if (desc_fire) begin
                desc_addr <= desc_addr + desc_len;
                desc_rem  <= desc_rem - desc_len;
            end
            if (beat) begin
                beat_cnt  <= beat_cnt + 32'd1;
                data_addr <= data_addr_nxt;
                if (dma.dma_rd_read_data_tlast != beat_last_exp) err_tlast <= 1'b1;
            end
            unique case ({desc_fire, tlast_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // FIFO write stage: fixed one-cycle latency from beat to write strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dma.w_fifo_wr_en <= 1'b0;
            dma.w_fifo_din   <= '0;
        end else begin
            dma.w_fifo_wr_en <= beat;
            if (beat) dma.w_fifo_din <= lanes;
        end
    end
endmodule

// File: tb/tb_fc_w_fetch.sv
// Directed bench for fc_w_fetch: descriptor splitting, lane conversion,
// backpressure, zero-length transfer, reset mid-run and tlast error.
module tb_fc_w_fetch;
    localparam int DATA_W = 512;
    localparam int B      = DATA_W / 8;
    localparam int DW     = B * 9;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_pulse = 1'b0;
    logic [31:0] w_addr = '0;
    logic [31:0] w_n_bytes = '0;
    logic [7:0]  wz = '0;
    logic        done_pulse, busy, err_tlast;

    fc_w_fetch_if #(.DATA_W(DATA_W)) bus ();

    fc_w_fetch #(.DATA_W(DATA_W), .CHUNK_BYTES(4096), .MAX_OUT(2)) dut (
        .clk(clk), .rstn(rstn), .start_pulse(start_pulse), .w_addr(w_addr),
        .w_n_bytes(w_n_bytes), .wz(wz), .done_pulse(done_pulse), .busy(busy),
        .err_tlast(err_tlast), .dma(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, n_wr = 0, n_done = 0, last_wr_cyc = 0, done_cyc = 0, cur_left = 0;
    int pend_q[$];
    logic [31:0] da_q[$], dl_q[$];
    logic [DW-1:0] last_din = '0;
    logic [7:0] fill = 8'h00;
    bit ramp = 0, drop_tlast = 0;

    // Monitor: log descriptors, consumed beats, FIFO writes and done pulses.
    always @(posedge clk) begin
        cyc++;
        if (bus.dma_rd_desc_valid && bus.dma_rd_desc_ready) begin
            da_q.push_back(bus.dma_rd_desc_addr);
            dl_q.push_back(bus.dma_rd_desc_len);
            pend_q.push_back(int'(bus.dma_rd_desc_len) / B);
        end
        if (bus.dma_rd_read_data_tvalid && bus.dma_rd_read_data_tready && cur_left > 0)
            cur_left--;
        if (bus.w_fifo_wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            last_din = bus.w_fifo_din;
        end
        if (done_pulse) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // DMA read model: streams each accepted descriptor's beats in order.
    always @(negedge clk) begin
        if (cur_left == 0 && pend_q.size() > 0) cur_left = pend_q.pop_front();
        if (cur_left > 0) begin
            bus.dma_rd_read_data_tvalid = 1'b1;
            for (int i = 0; i < B; i++)
                bus.dma_rd_read_data_tdata[8*i +: 8] = ramp ? 8'(i) : fill;
            bus.dma_rd_read_data_tlast = (cur_left == 1) && !drop_tlast;
        end else begin
            bus.dma_rd_read_data_tvalid = 1'b0;
            bus.dma_rd_read_data_tlast  = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] n, input logic [7:0] z);
        @(negedge clk);
        w_addr = a; w_n_bytes = n; wz = z; start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0, k;
        n0 = n_done;
        k = 0;
        while (n_done == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (n_done != n0), 1'b1);
    endtask

    function automatic logic [DW-1:0] exp_din(input bit rmp, input logic [7:0] f, input logic [7:0] z);
        logic [7:0] b;
        exp_din = '0;
        for (int i = 0; i < B; i++) begin
            b = rmp ? 8'(i) : f;
            exp_din[9*i +: 9] = {1'b0, b} - {1'b0, z};
        end
    endfunction

    task automatic clear_log();
        da_q.delete(); dl_q.delete(); pend_q.delete();
        cur_left = 0; n_wr = 0; n_done = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_done"},  done_pulse, 1'b0);
        chk({tag, "_dvld"},  bus.dma_rd_desc_valid, 1'b0);
        chk({tag, "_trdy"},  bus.dma_rd_read_data_tready, 1'b0);
        chk({tag, "_wren"},  bus.w_fifo_wr_en, 1'b0);
        chk({tag, "_din"},   bus.w_fifo_din, '0);
        chk({tag, "_err"},   err_tlast, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] v180, v0ff;
        v180 = {B{9'h180}};
        v0ff = {B{9'h0FF}};
        bus.dma_rd_desc_ready       = 1'b1;
        bus.w_fifo_prog_full        = 1'b0;
        bus.dma_rd_read_data_tvalid = 1'b0;
        bus.dma_rd_read_data_tlast  = 1'b0;
        bus.dma_rd_read_data_tdata  = '0;

        // Reset state.
        @(negedge clk);
        chk_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        // Two full 4 KB chunks, zero data with wz=0x80; a second start mid-run is ignored.
        fill = 8'h00;
        do_start(32'h1000, 32'd8192, 8'h80);
        chk("A_busy", busy, 1'b1);
        repeat (10) @(negedge clk);
        do_start(32'h9000, 32'd64, 8'h00);
        wait_done("A_done", 400);
        chk("A_ndesc", da_q.size(), 2);
        chk("A_d0addr", da_q[0], 32'h1000);
        chk("A_d0len",  dl_q[0], 32'd4096);
        chk("A_d1addr", da_q[1], 32'h2000);
        chk("A_d1len",  dl_q[1], 32'd4096);
        chk("A_nwr", n_wr, 128);
        chk("A_done_lat", done_cyc - last_wr_cyc, 1);
        chk("A_ndone", n_done, 1);
        chk("A_lane0", last_din[8:0], 9'h180);
        chk("A_din", last_din, v180);
        chk("A_err", err_tlast, 1'b0);
        @(negedge clk);
        chk("A_idle", busy, 1'b0);

        // Start just below a chunk boundary: split into 64 + 128 bytes.
        clear_log();
        fill = 8'hFF;
        do_start(32'h0FC0, 32'd192, 8'h00);
        wait_done("B_done", 100);
        chk("B_ndesc", da_q.size(), 2);
        chk("B_d0addr", da_q[0], 32'h0FC0);
        chk("B_d0len",  dl_q[0], 32'd64);
        chk("B_d1addr", da_q[1], 32'h1000);
        chk("B_d1len",  dl_q[1], 32'd128);
        chk("B_nwr", n_wr, 3);
        chk("B_din", last_din, v0ff);
        chk("B_err", err_tlast, 1'b0);

        // Descriptor stall holds addr/len, then 10 cycles of prog_full mid-stream.
        clear_log();
        ramp = 1;
        bus.dma_rd_desc_ready = 1'b0;
        do_start(32'h0, 32'd2560, 8'h10);
        for (int k = 0; k < 3; k++) begin
            chk("C_stall_vld", bus.dma_rd_desc_valid, 1'b1);
            chk("C_stall_addr", bus.dma_rd_desc_addr, 32'h0);
            chk("C_stall_len", bus.dma_rd_desc_len, 32'd2560);
            @(negedge clk);
        end
        bus.dma_rd_desc_ready = 1'b1;
        repeat (4) @(negedge clk);
        bus.w_fifo_prog_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("C_pf_trdy0", bus.dma_rd_read_data_tready, 1'b0);
            @(negedge clk);
        end
        bus.w_fifo_prog_full = 1'b0;
        #1;
        chk("C_pf_trdy1", bus.dma_rd_read_data_tready, 1'b1);
        wait_done("C_done", 200);
        chk("C_ndesc", da_q.size(), 1);
        chk("C_d0len", dl_q[0], 32'd2560);
        chk("C_nwr", n_wr, 40);
        chk("C_din", last_din, exp_din(1'b1, 8'h00, 8'h10));
        chk("C_err", err_tlast, 1'b0);
        ramp = 0;

        // Zero-length transfer: one busy cycle, done on start+1.
        clear_log();
        do_start(32'h4000, 32'd0, 8'h00);
        chk("D_done1", done_pulse, 1'b1);
        chk("D_busy1", busy, 1'b1);
        @(negedge clk);
        chk("D_done0", done_pulse, 1'b0);
        chk("D_busy0", busy, 1'b0);
        chk("D_ndesc", da_q.size(), 0);

        // Reset mid-transfer, then a clean 128-byte run with tlast missing.
        clear_log();
        fill = 8'h5A;
        do_start(32'h0, 32'd8192, 8'h00);
        repeat (20) @(negedge clk);
        #2;
        rstn = 1'b0;
        clear_log();
        #1;
        chk_reset_outputs("E_rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("E_nodone", n_done, 0);
        drop_tlast = 1;
        do_start(32'h40, 32'd128, 8'h5A);
        wait_done("E_done", 100);
        repeat (3) @(negedge clk);
        chk("E_nwr", n_wr, 2);
        chk("E_ndone", n_done, 1);
        chk("E_din", last_din, '0);
        chk("E_err", err_tlast, 1'b1);
        drop_tlast = 0;

        // Sticky error clears on the next accepted start.
        do_start(32'h0, 32'd0, 8'h00);
        chk("F_errclr", err_tlast, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
